// File: rtl/mmu_pkg.sv
// mmu_pkg: shared constants for the Game Gear address decoder / bus mux.
//   - I/O port ranges (decoded on z80_addr[7:0])
//   - cartridge mapper register addresses
//   - reset values of the mapper bank registers and the system I/O registers
package mmu_pkg;

  // System I/O registers occupy ports PORT_GG_BASE .. PORT_GG_LAST.
  // Port 0 is the read-only start/region port, 1..5 are read/write.
  localparam logic [7:0] PORT_GG_BASE = 8'h00;
  localparam logic [7:0] PORT_GG_LAST = 8'h05;
  localparam logic [7:0] PORT_GG_ID   = 8'hC0;  // {start=1, region=1, 6'b0}
  localparam logic [7:0] PORT_OPEN    = 8'hFF;  // unmapped / no buttons

  // z80_addr[7:6] ranges
  localparam logic [1:0] RANGE_GG  = 2'b00;
  localparam logic [1:0] RANGE_CNT = 2'b01;  // V/H counters (PSG on write)
  localparam logic [1:0] RANGE_VDP = 2'b10;  // even=data, odd=control

  // Mapper bank register addresses (writes also land in RAM)
  localparam logic [15:0] MAP_BANK0_ADDR = 16'hFFFD;
  localparam logic [15:0] MAP_BANK1_ADDR = 16'hFFFE;
  localparam logic [15:0] MAP_BANK2_ADDR = 16'hFFFF;

  // First 1 KB of the cartridge is never banked
  localparam logic [15:0] MAP_FIXED_END = 16'h0400;

  // Reset values
  localparam logic [1:0] BANK0_RST = 2'd0;
  localparam logic [1:0] BANK1_RST = 2'd1;
  localparam logic [1:0] BANK2_RST = 2'd2;

  localparam logic [7:0] GG_REG1_RST = 8'h7F;
  localparam logic [7:0] GG_REG2_RST = 8'hFF;
  localparam logic [7:0] GG_REG3_RST = 8'h00;
  localparam logic [7:0] GG_REG4_RST = 8'hFF;
  localparam logic [7:0] GG_REG5_RST = 8'h00;

endpackage

// File: rtl/mmu_mapper.sv
// mmu_mapper: 3-slot cartridge bank mapper.
//   clk, rst      : clock, synchronous active-high reset
//   z80_addr      : CPU address bus
//   bank_wdata    : z80_do[1:0], new bank number on a mapper write
//   z80_mem_wr    : qualified memory write strobe
//   cart_addr     : banked cartridge address (combinational)
module mmu_mapper
  import mmu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z80_addr,
  input  logic [1:0]  bank_wdata,
  input  logic        z80_mem_wr,
  output logic [15:0] cart_addr
);

  logic [1:0] bank0;
  logic [1:0] bank1;
  logic [1:0] bank2;
  logic [1:0] bank_sel;

  // Re-written on every edge while the strobe is high; same value, so harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank0 <= BANK0_RST;
      bank1 <= BANK1_RST;
      bank2 <= BANK2_RST;
    end else if (z80_mem_wr) begin
      case (z80_addr)
        MAP_BANK0_ADDR: bank0 <= bank_wdata;
        MAP_BANK1_ADDR: bank1 <= bank_wdata;
        MAP_BANK2_ADDR: bank2 <= bank_wdata;
        default: ;
      endcase
    end
  end

  // Slot 3 (0xC000-0xFFFF) is RAM, so its cartridge page is a don't-care; 0 is used.
  always_comb begin
    bank_sel = 2'b00;
    if (z80_addr >= MAP_FIXED_END) begin
      case (z80_addr[15:14])
        2'd0:    bank_sel = bank0;
        2'd1:    bank_sel = bank1;
        2'd2:    bank_sel = bank2;
        default: bank_sel = 2'b00;
      endcase
    end
    cart_addr = {bank_sel, z80_addr[13:0]};
  end

endmodule

// File: rtl/mmu.sv
// mmu: Game Gear address decoder and CPU data-bus multiplexer.
//   clk, rst                      : clock, synchronous active-high reset
//   z80_addr/z80_do/z80_di        : CPU address, write data, read data
//   z80_mem_rd/wr, z80_io_rd/wr   : qualified CPU strobes
//   ram_we/ram_di/ram_do/ram_addr : 8 KB work RAM (mirrored at 0xE000)
//   cart_di/cart_do/cart_addr     : cartridge ROM, banked address
//   vdp_*_wr/rd                   : one-cycle pulses at the start of a VDP port access
//   vdp_control_o/vdp_data_o      : VDP status / read buffer
//   vdp_v_counter/vdp_h_counter   : VDP beam counters
// Valid/ready: there is no handshake; every strobe is an access qualifier and
// all decode/mux paths respond combinationally in the same cycle.
module mmu
  import mmu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z80_addr,
  input  logic [7:0]  z80_do,
  output logic [7:0]  z80_di,
  input  logic        z80_mem_rd,
  input  logic        z80_mem_wr,
  input  logic        z80_io_rd,
  input  logic        z80_io_wr,
  output logic        ram_we,
  output logic [7:0]  ram_di,
  input  logic [7:0]  ram_do,
  output logic [12:0] ram_addr,
  output logic [7:0]  cart_di,
  input  logic [7:0]  cart_do,
  output logic [15:0] cart_addr,
  output logic        vdp_control_wr,
  output logic        vdp_control_rd,
  output logic        vdp_data_wr,
  output logic        vdp_data_rd,
  input  logic [7:0]  vdp_control_o,
  input  logic [7:0]  vdp_data_o,
  input  logic [7:0]  vdp_v_counter,
  input  logic [7:0]  vdp_h_counter
);

  logic [7:0] port;
  logic       is_ram;
  logic       is_gg_rw;
  logic [7:0] gg_reg1, gg_reg2, gg_reg3, gg_reg4, gg_reg5;
  logic [7:0] io_rdata;
  logic [3:0] vdp_raw;    // {control_rd, control_wr, data_rd, data_wr}
  logic [3:0] vdp_raw_q;

  assign port     = z80_addr[7:0];
  assign is_ram   = (z80_addr[15:14] == 2'b11);
  assign is_gg_rw = (port > PORT_GG_BASE) && (port <= PORT_GG_LAST);

  assign ram_addr = z80_addr[12:0];
  assign ram_di   = z80_do;
  assign ram_we   = z80_mem_wr & is_ram;
  assign cart_di  = z80_do;

  mmu_mapper u_mapper (
    .clk        (clk),
    .rst        (rst),
    .z80_addr   (z80_addr),
    .bank_wdata (z80_do[1:0]),
    .z80_mem_wr (z80_mem_wr),
    .cart_addr  (cart_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gg_reg1 <= GG_REG1_RST;
      gg_reg2 <= GG_REG2_RST;
      gg_reg3 <= GG_REG3_RST;
      gg_reg4 <= GG_REG4_RST;
      gg_reg5 <= GG_REG5_RST;
    end else if (z80_io_wr && is_gg_rw) begin
      case (port[2:0])
        3'd1:    gg_reg1 <= z80_do;
        3'd2:    gg_reg2 <= z80_do;
        3'd3:    gg_reg3 <= z80_do;
        3'd4:    gg_reg4 <= z80_do;
        3'd5:    gg_reg5 <= z80_do;
        default: ;
      endcase
    end
  end

  always_comb begin
    io_rdata = PORT_OPEN;
    case (port[7:6])
      RANGE_GG: begin
        if (port == PORT_GG_BASE) io_rdata = PORT_GG_ID;
        else if (is_gg_rw) begin
          case (port[2:0])
            3'd1:    io_rdata = gg_reg1;
            3'd2:    io_rdata = gg_reg2;
            3'd3:    io_rdata = gg_reg3;
            3'd4:    io_rdata = gg_reg4;
            default: io_rdata = gg_reg5;
          endcase
        end
      end
      RANGE_CNT: io_rdata = port[0] ? vdp_h_counter : vdp_v_counter;
      RANGE_VDP: io_rdata = port[0] ? vdp_control_o : vdp_data_o;
      default:   io_rdata = PORT_OPEN;
    endcase
  end

  // Memory wins if both read strobes are ever seen together.
  always_comb begin
    z80_di = PORT_OPEN;
    if (z80_mem_rd)     z80_di = is_ram ? ram_do : cart_do;
    else if (z80_io_rd) z80_di = io_rdata;
  end

  always_comb begin
    vdp_raw = 4'b0000;
    if (port[7:6] == RANGE_VDP) begin
      vdp_raw[0] = z80_io_wr & ~port[0];
      vdp_raw[1] = z80_io_rd & ~port[0];
      vdp_raw[2] = z80_io_wr &  port[0];
      vdp_raw[3] = z80_io_rd &  port[0];
    end
  end

  // History is held at 0 during reset so an access spanning release still
  // produces its pulse in the first cycle after release.
  always_ff @(posedge clk) begin
    if (rst) vdp_raw_q <= 4'b0000;
    else     vdp_raw_q <= vdp_raw;
  end

  logic [3:0] vdp_pulse;
  assign vdp_pulse      = rst ? 4'b0000 : (vdp_raw & ~vdp_raw_q);
  assign vdp_data_wr    = vdp_pulse[0];
  assign vdp_data_rd    = vdp_pulse[1];
  assign vdp_control_wr = vdp_pulse[2];
  assign vdp_control_rd = vdp_pulse[3];

endmodule

// File: tb/tb_mmu.sv
module tb_mmu;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] z80_addr;
  logic [7:0]  z80_do, z80_di;
  logic        z80_mem_rd, z80_mem_wr, z80_io_rd, z80_io_wr;
  logic        ram_we;
  logic [7:0]  ram_di, ram_do;
  logic [12:0] ram_addr;
  logic [7:0]  cart_di, cart_do;
  logic [15:0] cart_addr;
  logic        vdp_control_wr, vdp_control_rd, vdp_data_wr, vdp_data_rd;
  logic [7:0]  vdp_control_o, vdp_data_o, vdp_v_counter, vdp_h_counter;
  logic [3:0]  pulses;

  always #5 clk = ~clk;

  mmu dut (
    .clk(clk), .rst(rst), .z80_addr(z80_addr), .z80_do(z80_do), .z80_di(z80_di),
    .z80_mem_rd(z80_mem_rd), .z80_mem_wr(z80_mem_wr),
    .z80_io_rd(z80_io_rd), .z80_io_wr(z80_io_wr),
    .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do), .ram_addr(ram_addr),
    .cart_di(cart_di), .cart_do(cart_do), .cart_addr(cart_addr),
    .vdp_control_wr(vdp_control_wr), .vdp_control_rd(vdp_control_rd),
    .vdp_data_wr(vdp_data_wr), .vdp_data_rd(vdp_data_rd),
    .vdp_control_o(vdp_control_o), .vdp_data_o(vdp_data_o),
    .vdp_v_counter(vdp_v_counter), .vdp_h_counter(vdp_h_counter)
  );

  // {control_rd, control_wr, data_rd, data_wr}
  assign pulses = {vdp_control_rd, vdp_control_wr, vdp_data_rd, vdp_data_wr};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  // One bus cycle: inputs change just after the rising edge, outputs are
  // sampled on the falling edge.
  task automatic step(input logic mr, input logic mw, input logic ir, input logic iw,
                      input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    z80_mem_rd = mr; z80_mem_wr = mw; z80_io_rd = ir; z80_io_wr = iw;
    z80_addr = a; z80_do = d;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    z80_mem_rd = 0; z80_mem_wr = 0; z80_io_rd = 0; z80_io_wr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        mr, mw, ir, iw;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [7:0]  exp_di;
    logic        exp_we;
    logic        chk_cart;
    logic [15:0] exp_cart;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [3:0] op, input logic [15:0] a,
                                  input logic [7:0] d, input logic [7:0] di, input logic we,
                                  input logic cc, input logic [15:0] ca, input logic [3:0] pl);
    vec_t v;
    {v.mr, v.mw, v.ir, v.iw} = op;
    v.addr = a; v.dout = d; v.exp_di = di; v.exp_we = we;
    v.chk_cart = cc; v.exp_cart = ca; v.exp_pulse = pl;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  logic [1:0] m_bank [3];
  logic [7:0] m_gg   [8];

  function automatic void model_reset();
    m_bank[0] = 2'd0; m_bank[1] = 2'd1; m_bank[2] = 2'd2;
    m_gg[1] = 8'h7F; m_gg[2] = 8'hFF; m_gg[3] = 8'h00; m_gg[4] = 8'hFF; m_gg[5] = 8'h00;
  endfunction

  function automatic logic [7:0] model_io(input logic [7:0] p);
    if (p == 8'h00) return 8'hC0;
    if (p <= 8'h05) return m_gg[p[2:0]];
    if (p < 8'h40)  return 8'hFF;
    if (p < 8'h80)  return (p % 2 == 1) ? vdp_h_counter : vdp_v_counter;
    if (p < 8'hC0)  return (p % 2 == 1) ? vdp_control_o : vdp_data_o;
    return 8'hFF;
  endfunction

  function automatic logic [15:0] model_cart(input logic [15:0] a);
    int slot;
    if (a < 16'h0400) return a & 16'h3FFF;
    slot = a / 16'h4000;
    return (16'(m_bank[slot]) * 16'h4000) + (a % 16'h4000);
  endfunction

  // Which VDP ports the current access addresses (bit order as "pulses").
  function automatic logic [3:0] model_vdp(input logic ir, input logic iw, input logic [15:0] a);
    logic [3:0] r = 4'b0000;
    if (a[7:0] >= 8'h80 && a[7:0] < 8'hC0) begin
      if (a[7:0] % 2 == 0) begin r[0] = iw; r[1] = ir; end
      else                 begin r[2] = iw; r[3] = ir; end
    end
    return r;
  endfunction

  // ---------------- test ----------------
  initial begin : main
    int cnt;
    logic mr, mw, ir, iw;
    logic [15:0] a;
    logic [7:0]  d;
    logic [3:0]  prev;
    logic [3:0]  cur;
    logic [7:0]  exp_di;

    rst = 1'b1;
    z80_mem_rd = 0; z80_mem_wr = 0; z80_io_rd = 0; z80_io_wr = 0;
    z80_addr = 16'h0; z80_do = 8'h0;
    cart_do = 8'hA5; ram_do = 8'h3C;
    vdp_control_o = 8'h80; vdp_data_o = 8'h55; vdp_v_counter = 8'h12; vdp_h_counter = 8'h34;

    // Access spanning reset release: no pulse in reset, one right after.
    @(posedge clk); #1;
    z80_io_wr = 1'b1; z80_addr = 16'h00BE; z80_do = 8'h11;
    @(negedge clk);
    check("pulse_in_reset_a", pulses, 4'b0000);
    @(negedge clk);
    check("pulse_in_reset_b", pulses, 4'b0000);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("pulse_after_release", pulses, 4'b0001);
    @(negedge clk);
    check("pulse_after_release_held", pulses, 4'b0000);
    idle();

    // Table: reset state and combinational decode.
    add_vec(4'b0000, 16'h0000, 8'h00, 8'hFF, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b1000, 16'h4123, 8'h00, 8'hA5, 0, 1, 16'h4123, 4'b0000);
    add_vec(4'b1000, 16'h8010, 8'h00, 8'hA5, 0, 1, 16'h8010, 4'b0000);
    add_vec(4'b1000, 16'h0200, 8'h00, 8'hA5, 0, 1, 16'h0200, 4'b0000);
    add_vec(4'b1000, 16'h2000, 8'h00, 8'hA5, 0, 1, 16'h2000, 4'b0000);
    add_vec(4'b1000, 16'hBFFF, 8'h00, 8'hA5, 0, 1, 16'hBFFF, 4'b0000);
    add_vec(4'b1000, 16'hC123, 8'h00, 8'h3C, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b1000, 16'hFFFF, 8'h00, 8'h3C, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0100, 16'hE005, 8'h5A, 8'hFF, 1, 0, 16'h0000, 4'b0000);
    add_vec(4'b0100, 16'h8000, 8'h5A, 8'hFF, 0, 1, 16'h8000, 4'b0000);
    add_vec(4'b0010, 16'h0000, 8'h00, 8'hC0, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h0001, 8'h00, 8'h7F, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h0002, 8'h00, 8'hFF, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h0003, 8'h00, 8'h00, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h0004, 8'h00, 8'hFF, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h0005, 8'h00, 8'h00, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h0006, 8'h00, 8'hFF, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h003F, 8'h00, 8'hFF, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h007E, 8'h00, 8'h12, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h007F, 8'h00, 8'h34, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h0040, 8'h00, 8'h12, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h00BE, 8'h00, 8'h55, 0, 0, 16'h0000, 4'b0010);
    add_vec(4'b0010, 16'h00BF, 8'h00, 8'h80, 0, 0, 16'h0000, 4'b1000);
    add_vec(4'b0001, 16'h00BF, 8'h00, 8'hFF, 0, 0, 16'h0000, 4'b0100);
    add_vec(4'b0010, 16'h00DC, 8'h00, 8'hFF, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h00C0, 8'h00, 8'hFF, 0, 0, 16'h0000, 4'b0000);
    add_vec(4'b0010, 16'h1201, 8'h00, 8'h7F, 0, 0, 16'h0000, 4'b0000);

    foreach (vecs[i]) begin
      step(vecs[i].mr, vecs[i].mw, vecs[i].ir, vecs[i].iw, vecs[i].addr, vecs[i].dout);
      check($sformatf("vec%0d_di", i), z80_di, vecs[i].exp_di);
      check($sformatf("vec%0d_we", i), ram_we, vecs[i].exp_we);
      check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].addr % 16'h2000);
      check($sformatf("vec%0d_ram_di", i), ram_di, vecs[i].dout);
      check($sformatf("vec%0d_cart_di", i), cart_di, vecs[i].dout);
      check($sformatf("vec%0d_pulse", i), pulses, vecs[i].exp_pulse);
      if (vecs[i].chk_cart) check($sformatf("vec%0d_cart", i), cart_addr, vecs[i].exp_cart);
      idle();
    end

    // Mapper: bank2 <= 3, write also reaches RAM.
    step(0, 1, 0, 0, 16'hFFFF, 8'h03);
    check("bank2_wr_ram_we", ram_we, 1);
    idle();
    step(1, 0, 0, 0, 16'h8010, 8'h00);
    check("bank2_cart", cart_addr, 16'hC010);
    // bank0 <= 3; first 1 KB stays fixed.
    step(0, 1, 0, 0, 16'hFFFD, 8'hFF);
    idle();
    step(1, 0, 0, 0, 16'h0200, 8'h00);
    check("fixed_0200", cart_addr, 16'h0200);
    step(1, 0, 0, 0, 16'h03FF, 8'h00);
    check("fixed_03ff", cart_addr, 16'h03FF);
    step(1, 0, 0, 0, 16'h0400, 8'h00);
    check("bank0_0400", cart_addr, 16'hC400);
    step(1, 0, 0, 0, 16'h3FFF, 8'h00);
    check("bank0_3fff", cart_addr, 16'hFFFF);
    // 0xFFFC: RAM only, mapper untouched.
    step(0, 1, 0, 0, 16'hFFFC, 8'h01);
    check("fffc_ram_we", ram_we, 1);
    idle();
    step(1, 0, 0, 0, 16'h0400, 8'h00);
    check("fffc_bank0_kept", cart_addr, 16'hC400);
    step(1, 0, 0, 0, 16'h4000, 8'h00);
    check("fffc_bank1_kept", cart_addr, 16'h4000);

    // gg_reg write/readback; port 0 writes ignored.
    step(0, 0, 0, 1, 16'h0001, 8'h42);
    idle();
    step(0, 0, 1, 0, 16'h0001, 8'h00);
    check("gg1_readback", z80_di, 8'h42);
    step(0, 0, 0, 1, 16'h0000, 8'h11);
    idle();
    step(0, 0, 1, 0, 16'h0000, 8'h00);
    check("port0_ro", z80_di, 8'hC0);

    // Held VDP data write: one pulse in four cycles.
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 16'h00BE, 8'h77);
      cnt += int'(vdp_data_wr);
    end
    check("held_data_wr_pulses", cnt, 1);
    idle();
    // Two accesses with one idle cycle between: two pulses.
    cnt = 0;
    step(0, 0, 0, 1, 16'h00BE, 8'h01); cnt += int'(vdp_data_wr);
    idle();                            cnt += int'(vdp_data_wr);
    step(0, 0, 0, 1, 16'h00BE, 8'h02); cnt += int'(vdp_data_wr);
    check("b2b_data_wr_pulses", cnt, 2);
    idle();
    // Held control read: data for whole access, one pulse.
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0, 16'h00BF, 8'h00);
      check($sformatf("ctrl_rd_di%0d", k), z80_di, 8'h80);
      cnt += int'(vdp_control_rd);
    end
    check("held_ctrl_rd_pulses", cnt, 1);
    // Counter reads: no VDP pulses.
    step(0, 0, 1, 0, 16'h007E, 8'h00);
    check("v_cnt_di", z80_di, 8'h12);
    check("v_cnt_pulse", pulses, 4'b0000);
    step(0, 0, 1, 0, 16'h007F, 8'h00);
    check("h_cnt_di", z80_di, 8'h34);
    check("h_cnt_pulse", pulses, 4'b0000);
    // Overlapping memory and I/O read: memory wins.
    step(1, 0, 1, 0, 16'h10BF, 8'h00);
    check("mem_over_io", z80_di, 8'hA5);
    idle();

    // Reset restores banks and gg_regs.
    do_reset();
    step(1, 0, 0, 0, 16'h0400, 8'h00);
    check("rst_bank0", cart_addr, 16'h0400);
    step(1, 0, 0, 0, 16'h8000, 8'h00);
    check("rst_bank2", cart_addr, 16'h8000);
    step(0, 0, 1, 0, 16'h0001, 8'h00);
    check("rst_gg1", z80_di, 8'h7F);
    idle();

    // Random stimulus against the reference model.
    model_reset();
    prev = 4'b0000;
    mr = 0; mw = 0; ir = 0; iw = 0; a = 16'h0; d = 8'h0;
    for (int n = 0; n < 2000; n++) begin
      int op = $urandom_range(0, 5);
      if (op != 5) begin
        {mr, mw, ir, iw} = 4'b0000;
        a = 16'($urandom);
        d = 8'($urandom);
        case (op)
          1: mr = 1;
          2: begin
            mw = 1;
            if ($urandom_range(0, 2) == 0) a = 16'hFFFC + 16'($urandom_range(0, 3));
          end
          3: ir = 1;
          4: iw = 1;
          default: ;
        endcase
        if ((ir || iw) && $urandom_range(0, 2) == 0) a[7:0] = 8'($urandom_range(0, 7));
      end
      cart_do = 8'($urandom); ram_do = 8'($urandom);
      vdp_control_o = 8'($urandom); vdp_data_o = 8'($urandom);
      vdp_v_counter = 8'($urandom); vdp_h_counter = 8'($urandom);
      step(mr, mw, ir, iw, a, d);

      if (mr)      exp_di = (a >= 16'hC000) ? ram_do : cart_do;
      else if (ir) exp_di = model_io(a[7:0]);
      else         exp_di = 8'hFF;
      cur = model_vdp(ir, iw, a);
      check("rnd_di", z80_di, exp_di);
      check("rnd_we", ram_we, mw && a >= 16'hC000);
      check("rnd_ram_addr", ram_addr, a % 16'h2000);
      check("rnd_ram_di", ram_di, d);
      check("rnd_cart_di", cart_di, d);
      check("rnd_pulse", pulses, cur & ~prev);
      if (a < 16'hC000) check("rnd_cart", cart_addr, model_cart(a));
      prev = cur;

      // State changes land at the coming clock edge.
      if (mw && a >= 16'hFFFD) m_bank[a - 16'hFFFD] = d[1:0];
      if (iw && a[7:0] >= 8'h01 && a[7:0] <= 8'h05) m_gg[a[2:0]] = d;
    end

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
